// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- HI/LO multiply/divide scheduler for the EXE stage.
//
// Takes one MULT/MULTU/DIV/DIVU per issue, computes the 64-bit result at
// issue time into a shadow register, counts out a fixed latency and then
// commits it to the architectural HI/LO pair. MTHI/MTLO write HI/LO on the
// issue edge with no latency. While an op is in flight, busy_o is high and
// any D-stage HI/LO user is held off through md_stall_o.
//
// Optional feature macro: MD_SCHED_MADD_EN
//   defined   : op 7 = MADD, {hi,lo} += signed(src_a*src_b), MULT latency
//   undefined : op 7 behaves as NOP
//
// Parameters:
//   MULT_CYCLES  issue-to-commit cycles for MULT/MULTU (and MADD), 1..15
//   DIV_CYCLES   issue-to-commit cycles for DIV/DIVU, 1..15
//
// Ports:
//   clk_i       system clock, rising edge
//   reset_i     asynchronous active-high reset
//   start_i     EXE-stage md instruction valid this cycle
//   op_i        0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD
//   src_a_i     forwarded rs value
//   src_b_i     forwarded rt value
//   md_useD_i   D-stage instruction uses HI/LO or the md unit
//   busy_o      operation in flight
//   hi_o, lo_o  architectural HI / LO
//   md_stall_o  stall request to the hazard unit
// ---------------------------------------------------------------------------
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        md_useD_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        md_stall_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    // The MUL/DIV kind only matters for the latency, which is fully
    // captured by the counter load value, so no separate kind register.
    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] shadow_q, shadow_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // ---------------- combinational arithmetic ----------------
    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic [31:0] divu_q, divu_r;
    logic [31:0] mag_a, mag_b, mag_q, mag_r;
    logic [31:0] divs_q, divs_r;
    logic        div_zero;
    logic        is_md_op;

    // Low 64 bits of a product of sign-extended operands equal the signed
    // 32x32 product.
    assign a_sx   = {{32{src_a_i[31]}}, src_a_i};
    assign b_sx   = {{32{src_b_i[31]}}, src_b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

    assign div_zero = (src_b_i == 32'd0);
    assign divu_q   = src_a_i / src_b_i;
    assign divu_r   = src_a_i % src_b_i;

    // Signed divide via magnitudes. 0x8000_0000 / -1 falls out naturally:
    // magnitude quotient 0x8000_0000, negation leaves it unchanged, rem 0.
    assign mag_a  = src_a_i[31] ? (32'd0 - src_a_i) : src_a_i;
    assign mag_b  = src_b_i[31] ? (32'd0 - src_b_i) : src_b_i;
    assign mag_q  = mag_a / mag_b;
    assign mag_r  = mag_a % mag_b;
    assign divs_q = (src_a_i[31] ^ src_b_i[31]) ? (32'd0 - mag_q) : mag_q;
    assign divs_r = src_a_i[31] ? (32'd0 - mag_r) : mag_r;

`ifdef MD_SCHED_MADD_EN
    logic [63:0] madd_sum;
    // HI/LO is always committed here because issue requires IDLE.
    assign madd_sum = {hi_q, lo_q} + prod_s;
    assign is_md_op = (op_i >= OP_MULT && op_i <= OP_DIVU) || (op_i == OP_MADD);
`else
    assign is_md_op = (op_i >= OP_MULT && op_i <= OP_DIVU);
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == ST_IDLE) begin
            if (start_i) begin
                case (op_i)
                    OP_MULT: begin
                        shadow_d = prod_s;
                        cnt_d    = MULT_LOAD;
                        state_d  = ST_RUN;
                    end
                    OP_MULTU: begin
                        shadow_d = prod_u;
                        cnt_d    = MULT_LOAD;
                        state_d  = ST_RUN;
                    end
                    OP_DIV: begin
                        shadow_d = div_zero ? {src_a_i, 32'hFFFF_FFFF} : {divs_r, divs_q};
                        cnt_d    = DIV_LOAD;
                        state_d  = ST_RUN;
                    end
                    OP_DIVU: begin
                        shadow_d = div_zero ? {src_a_i, 32'hFFFF_FFFF} : {divu_r, divu_q};
                        cnt_d    = DIV_LOAD;
                        state_d  = ST_RUN;
                    end
                    OP_MTHI: hi_d = src_a_i;
                    OP_MTLO: lo_d = src_a_i;
`ifdef MD_SCHED_MADD_EN
                    OP_MADD: begin
                        shadow_d = madd_sum;
                        cnt_d    = MULT_LOAD;
                        state_d  = ST_RUN;
                    end
`endif
                    default: ;
                endcase
            end
        end else begin
            // start_i is ignored here; the hazard unit keeps it low via md_stall_o.
            if (cnt_q == 4'd0) begin
                hi_d    = shadow_q[63:32];
                lo_d    = shadow_q[31:0];
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            shadow_q <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // ---------------- outputs ----------------
    assign busy_o     = (state_q == ST_RUN);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign md_stall_o = md_useD_i & (busy_o | (start_i & is_md_op));

endmodule
